// File: rtl/atm_session_ctrl.sv
// rtl/atm_session_ctrl.sv - parametrised ATM card session controller
module atm_session_ctrl #(
  parameter int                AMT_W        = 32,
  parameter int                PIN_W        = 14,
  parameter int                ACCT_W       = 16,
  parameter int                MAX_TRIES    = 3,
  parameter int                TIMEOUT_CYC  = 1000,
  parameter int                INIT_BALANCE = 100000,
  parameter int                PIN_VALUE    = 8030,
  parameter logic [ACCT_W-1:0] DEST_ACCT    = 16'hD903,
  parameter int                WD_LIMIT     = 20000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             card_in,
  input  logic                             pin_valid,
  input  logic [PIN_W-1:0]                 pin,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [2:0]                       opcode,
  input  logic [AMT_W-1:0]                 amount,
  input  logic [ACCT_W-1:0]                dest_acct,
  input  logic                             receipt_req,
  output logic [AMT_W-1:0]                 balance,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
  output logic                             op_done,
  output logic [2:0]                       err_code,
  output logic                             receipt_print,
  output logic                             card_eject,
  output logic                             card_retained,
  output logic                             session_active
);

  localparam int TRY_W = $clog2(MAX_TRIES+1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC+1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYC-1);
  localparam logic [AMT_W:0]   WD_LIM_EXT = (AMT_W+1)'(WD_LIMIT);

  typedef enum logic [3:0] {
    S_IDLE, S_PIN, S_HOME, S_EXEC, S_RESP, S_RECEIPT, S_RETAIN, S_EJECT, S_WAIT_REMOVE
  } state_t;

  state_t state, next_state;

  logic [AMT_W-1:0]  wd_acc;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [2:0]        cap_op;
  logic [AMT_W-1:0]  cap_amt;
  logic [ACCT_W-1:0] cap_dest;
  logic              cap_rcpt;

  logic [AMT_W:0]    sum_wd, sum_dep;
  logic [2:0]        exec_err;
  logic [AMT_W-1:0]  bal_next, acc_next;
  logic              timeout_hit;

  // Widened sums so withdraw-limit and deposit-overflow checks see the carry
  assign sum_wd  = {1'b0, wd_acc}  + {1'b0, cap_amt};
  assign sum_dep = {1'b0, balance} + {1'b0, cap_amt};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic and transaction evaluation during EXEC
  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    exec_err    = 3'd0;
    bal_next    = balance;
    acc_next    = wd_acc;
    case (state)
      S_IDLE: if (card_in) next_state = S_PIN;
      S_PIN: begin
        if (!card_in) next_state = S_IDLE;
        else if (pin_valid) begin
          if (pin == PIN_W'(PIN_VALUE))      next_state = S_HOME;
          else if (tries_left == TRY_W'(1)) next_state = S_RETAIN;
        end else if (tmo_cnt == TMO_LAST) begin
          timeout_hit = 1'b1;
          next_state  = S_EJECT;
        end
      end
      S_HOME: begin
        if (!card_in) next_state = S_IDLE;
        else if (cmd_valid) next_state = S_EXEC;
        else if (tmo_cnt == TMO_LAST) begin
          timeout_hit = 1'b1;
          next_state  = S_EJECT;
        end
      end
      S_EXEC: begin
        next_state = S_RESP;
        case (cap_op)
          3'b000: next_state = S_EJECT;
          3'b001: exec_err = 3'd0;
          3'b010: begin
            if (cap_amt == '0)              exec_err = 3'd5;
            else if (cap_amt > balance)     exec_err = 3'd1;
            else if (sum_wd > WD_LIM_EXT)   exec_err = 3'd2;
            else begin
              bal_next = balance - cap_amt;
              acc_next = sum_wd[AMT_W-1:0];
            end
          end
          3'b011: begin
            if (cap_amt == '0)        exec_err = 3'd5;
            else if (sum_dep[AMT_W])  exec_err = 3'd3;
            else                      bal_next = sum_dep[AMT_W-1:0];
          end
          3'b100: begin
            if (cap_amt == '0)               exec_err = 3'd5;
            else if (cap_dest != DEST_ACCT)  exec_err = 3'd4;
            else if (cap_amt > balance)      exec_err = 3'd1;
            else                             bal_next = balance - cap_amt;
          end
          default: exec_err = 3'd6;
        endcase
      end
      S_RESP:        next_state = (err_code == 3'd0 && cap_rcpt) ? S_RECEIPT : S_HOME;
      S_RECEIPT:     next_state = S_HOME;
      S_RETAIN:      next_state = S_WAIT_REMOVE;
      S_EJECT:       next_state = S_WAIT_REMOVE;
      S_WAIT_REMOVE: if (!card_in) next_state = S_IDLE;
      default:       next_state = S_IDLE;
    endcase
  end

  // Datapath registers and registered outputs, all derived from the upcoming state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      balance        <= AMT_W'(INIT_BALANCE);
      tries_left     <= TRY_W'(MAX_TRIES);
      wd_acc         <= '0;
      tmo_cnt        <= '0;
      cap_op         <= 3'd0;
      cap_amt        <= '0;
      cap_dest       <= '0;
      cap_rcpt       <= 1'b0;
      cmd_ready      <= 1'b0;
      op_done        <= 1'b0;
      err_code       <= 3'd0;
      receipt_print  <= 1'b0;
      card_eject     <= 1'b0;
      card_retained  <= 1'b0;
      session_active <= 1'b0;
    end else begin
      cmd_ready      <= (next_state == S_HOME);
      session_active <= (next_state inside {S_PIN, S_HOME, S_EXEC, S_RESP, S_RECEIPT});
      op_done        <= (next_state == S_RESP) || timeout_hit;
      receipt_print  <= (next_state == S_RECEIPT);
      card_eject     <= (next_state == S_EJECT);
      card_retained  <= (next_state == S_RETAIN);

      if (state == S_IDLE && next_state == S_PIN) begin
        tries_left <= TRY_W'(MAX_TRIES);
        wd_acc     <= '0;
      end

      if (state == S_PIN && card_in && pin_valid && pin != PIN_W'(PIN_VALUE))
        tries_left <= tries_left - TRY_W'(1);

      if (state == S_PIN || state == S_HOME) begin
        if ((state == S_PIN && pin_valid) || (state == S_HOME && cmd_valid)) tmo_cnt <= '0;
        else                                                                 tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
        tmo_cnt <= '0;
      end

      if (state == S_HOME && next_state == S_EXEC) begin
        cap_op   <= opcode;
        cap_amt  <= amount;
        cap_dest <= dest_acct;
        cap_rcpt <= receipt_req;
      end

      if (state == S_EXEC) begin
        balance <= bal_next;
        wd_acc  <= acc_next;
        if (cap_op != 3'b000) err_code <= exec_err;
      end

      if (timeout_hit) err_code <= 3'd7;
    end
  end

endmodule
